// File: rtl/sim_run_monitor.sv
// Run controller and data-bus monitor: gates the processor enable, counts run and stall
// cycles, stops on a kill-address write or timeout, and logs accepted writes in a FIFO.
module sim_run_monitor #(
    parameter int                DATA_W     = 16,
    parameter int                ADDR_W     = 16,
    parameter logic [ADDR_W-1:0] KILL_ADDR  = '1,
    parameter int                MAX_CYCLES = 10000,
    parameter int                LOG_DEPTH  = 8,
    parameter int                CNT_W      = 32
) (
    input  logic                         Clock,
    input  logic                         Resetn,
    input  logic                         Start,
    input  logic                         Clear,
    input  logic                         WriteData,
    input  logic                         ReadData,
    input  logic [ADDR_W-1:0]            DataAddr,
    input  logic [DATA_W-1:0]            DataOut,
    input  logic                         Waitreq,
    output logic                         Enable,
    output logic                         Halted,
    output logic                         TimedOut,
    output logic [CNT_W-1:0]             CycleCount,
    output logic [CNT_W-1:0]             StallCount,
    input  logic                         LogPop,
    output logic                         LogValid,
    output logic [ADDR_W-1:0]            LogAddr,
    output logic [DATA_W-1:0]            LogData,
    output logic [$clog2(LOG_DEPTH):0]   LogCount,
    output logic                         LogOverflow,
    output logic [1:0]                   dbg_state
);

    localparam int PTR_W = $clog2(LOG_DEPTH);
    localparam logic [PTR_W:0]   FULL_CNT = LOG_DEPTH[PTR_W:0];
    localparam logic [CNT_W-1:0] MAX_CNT  = MAX_CYCLES[CNT_W-1:0];

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT, S_TIMEOUT} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cycle_q, cycle_d;
    logic [CNT_W-1:0]   stall_q, stall_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]     count_q, count_d;
    logic               ovf_q, ovf_d;
    logic [ADDR_W-1:0]  addr_mem_q [LOG_DEPTH];
    logic [DATA_W-1:0]  data_mem_q [LOG_DEPTH];

    logic             running, accepted, kill, hit_max;
    logic             push, pop, full, push_ok;
    logic [CNT_W-1:0] cycle_inc;

    assign running   = (state_q == S_RUN);
    assign accepted  = running & WriteData & ~Waitreq;
    assign kill      = accepted & (DataAddr == KILL_ADDR);
    assign cycle_inc = cycle_q + 1'b1;
    assign hit_max   = (cycle_inc == MAX_CNT);

    // A full log still accepts a push when the head is popped on the same edge.
    assign full    = (count_q == FULL_CNT);
    assign push    = accepted & ~kill & ~Clear;
    assign pop     = LogPop & (count_q != '0) & ~Clear;
    assign push_ok = push & (~full | pop);

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q  <= S_IDLE;
            cycle_q  <= '0;
            stall_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cycle_q  <= cycle_d;
            stall_q  <= stall_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge Clock) begin
        if (push_ok) begin
            addr_mem_q[wr_ptr_q] <= DataAddr;
            data_mem_q[wr_ptr_q] <= DataOut;
        end
    end

    // Kill is tested before the timeout so a simultaneous kill ends in HALT.
    always_comb begin
        state_d = state_q;
        if (Clear) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (Start) state_d = S_RUN;
                S_RUN: begin
                    if (kill)         state_d = S_HALT;
                    else if (hit_max) state_d = S_TIMEOUT;
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        cycle_d  = cycle_q;
        stall_d  = stall_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (Clear) begin
            cycle_d  = '0;
            stall_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            if (running) begin
                cycle_d = cycle_inc;
                if ((WriteData | ReadData) & Waitreq & (stall_q != '1))
                    stall_d = stall_q + 1'b1;
            end
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
            if (push_ok & ~pop)      count_d = count_q + 1'b1;
            else if (pop & ~push_ok) count_d = count_q - 1'b1;
            if (push & full & ~pop)  ovf_d = 1'b1;
        end
    end

    always_comb begin
        Enable      = (state_q == S_RUN);
        Halted      = (state_q == S_HALT);
        TimedOut    = (state_q == S_TIMEOUT);
        CycleCount  = cycle_q;
        StallCount  = stall_q;
        LogValid    = (count_q != '0);
        LogCount    = count_q;
        LogOverflow = ovf_q;
        LogAddr     = LogValid ? addr_mem_q[rd_ptr_q] : '0;
        LogData     = LogValid ? data_mem_q[rd_ptr_q] : '0;
        dbg_state   = state_q;
    end

endmodule

// File: tb/tb_sim_run_monitor.sv
// Directed bench for sim_run_monitor with MAX_CYCLES=20 and a 4-entry log:
// a vector table for log behaviour plus hand sequences for kill, stall, timeout and reset.
module tb_sim_run_monitor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, clear, wr, rd, wreq, pop;
    logic [15:0] addr, dout;
    logic        enable, halted, timed_out, log_valid, log_ovf;
    logic [31:0] cycle_cnt, stall_cnt;
    logic [15:0] log_addr, log_data;
    logic [2:0]  log_count;
    logic [1:0]  dbg_state;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    sim_run_monitor #(
        .DATA_W(16), .ADDR_W(16), .KILL_ADDR(16'hFFFF),
        .MAX_CYCLES(20), .LOG_DEPTH(4), .CNT_W(32)
    ) dut (
        .Clock(clk), .Resetn(rst_n), .Start(start), .Clear(clear),
        .WriteData(wr), .ReadData(rd), .DataAddr(addr), .DataOut(dout),
        .Waitreq(wreq), .Enable(enable), .Halted(halted), .TimedOut(timed_out),
        .CycleCount(cycle_cnt), .StallCount(stall_cnt), .LogPop(pop),
        .LogValid(log_valid), .LogAddr(log_addr), .LogData(log_data),
        .LogCount(log_count), .LogOverflow(log_ovf), .dbg_state(dbg_state)
    );

    typedef struct {
        logic        clr, st, w, r, wq, p;
        logic [15:0] a, d;
        logic        e_en, e_halt, e_to, e_valid, e_ovf;
        logic [31:0] e_cyc, e_stall;
        logic [2:0]  e_cnt;
        logic [15:0] e_addr, e_data;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic clr, st, w, r, wq, p, input logic [15:0] a, d,
        input logic e_en, e_halt, e_to, input logic [31:0] e_cyc, e_stall,
        input logic e_valid, input logic [2:0] e_cnt, input logic [15:0] e_addr, e_data,
        input logic e_ovf);
        vec_t v;
        v.clr = clr; v.st = st; v.w = w; v.r = r; v.wq = wq; v.p = p; v.a = a; v.d = d;
        v.e_en = e_en; v.e_halt = e_halt; v.e_to = e_to; v.e_cyc = e_cyc; v.e_stall = e_stall;
        v.e_valid = e_valid; v.e_cnt = e_cnt; v.e_addr = e_addr; v.e_data = e_data; v.e_ovf = e_ovf;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic check_outs(input string tag, input logic e_en, e_halt, e_to,
                              input logic [31:0] e_cyc, e_stall, input logic e_valid,
                              input logic [2:0] e_cnt, input logic [15:0] e_addr, e_data,
                              input logic e_ovf);
        chk({tag, ".Enable"},      {31'd0, enable},    {31'd0, e_en});
        chk({tag, ".Halted"},      {31'd0, halted},    {31'd0, e_halt});
        chk({tag, ".TimedOut"},    {31'd0, timed_out}, {31'd0, e_to});
        chk({tag, ".CycleCount"},  cycle_cnt,          e_cyc);
        chk({tag, ".StallCount"},  stall_cnt,          e_stall);
        chk({tag, ".LogValid"},    {31'd0, log_valid}, {31'd0, e_valid});
        chk({tag, ".LogCount"},    {29'd0, log_count}, {29'd0, e_cnt});
        chk({tag, ".LogAddr"},     {16'd0, log_addr},  {16'd0, e_addr});
        chk({tag, ".LogData"},     {16'd0, log_data},  {16'd0, e_data});
        chk({tag, ".LogOverflow"}, {31'd0, log_ovf},   {31'd0, e_ovf});
    endtask

    // Drive inputs on the falling edge, let one rising edge happen, sample 1 ns later.
    task automatic step(input logic c, s, w_i, r_i, wq_i, p_i, input logic [15:0] a_i, d_i);
        @(negedge clk);
        clear = c; start = s; wr = w_i; rd = r_i; wreq = wq_i; pop = p_i; addr = a_i; dout = d_i;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 16'h0, 16'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        {start, clear, wr, rd, wreq, pop} = '0;
        addr = '0; dout = '0;

        // Log vectors: overflow, in-order pops, empty pop, idle bus ignored, full push+pop, wrap.
        tbl.push_back(mk(1,0,0,0,0,0, 16'h0,16'h0,    0,0,0, 0,0, 0,0, 16'h0,16'h0, 0));
        tbl.push_back(mk(0,1,0,0,0,0, 16'h0,16'h0,    1,0,0, 0,0, 0,0, 16'h0,16'h0, 0));
        for (int i = 0; i < 6; i++)
            tbl.push_back(mk(0,0,1,0,0,0, 16'h10+16'(i), 16'hA0+16'(i),
                             1,0,0, 32'(i+1),0, 1, (i < 4) ? 3'(i+1) : 3'd4,
                             16'h10,16'hA0, (i >= 4)));
        tbl.push_back(mk(0,0,1,0,0,0, 16'hFFFF,16'h55, 0,1,0, 7,0, 1,4, 16'h10,16'hA0, 1));
        tbl.push_back(mk(0,0,0,0,0,1, 16'h0,16'h0,    0,1,0, 7,0, 1,3, 16'h11,16'hA1, 1));
        tbl.push_back(mk(0,0,0,0,0,1, 16'h0,16'h0,    0,1,0, 7,0, 1,2, 16'h12,16'hA2, 1));
        tbl.push_back(mk(0,0,0,0,0,1, 16'h0,16'h0,    0,1,0, 7,0, 1,1, 16'h13,16'hA3, 1));
        tbl.push_back(mk(0,0,0,0,0,1, 16'h0,16'h0,    0,1,0, 7,0, 0,0, 16'h0,16'h0,   1));
        tbl.push_back(mk(0,0,0,0,0,1, 16'h0,16'h0,    0,1,0, 7,0, 0,0, 16'h0,16'h0,   1));
        tbl.push_back(mk(0,1,0,0,0,0, 16'h0,16'h0,    0,1,0, 7,0, 0,0, 16'h0,16'h0,   1));
        tbl.push_back(mk(1,0,0,0,0,0, 16'h0,16'h0,    0,0,0, 0,0, 0,0, 16'h0,16'h0,   0));
        tbl.push_back(mk(0,0,1,0,1,0, 16'h30,16'h1,   0,0,0, 0,0, 0,0, 16'h0,16'h0,   0));
        tbl.push_back(mk(0,0,1,0,0,0, 16'h31,16'h2,   0,0,0, 0,0, 0,0, 16'h0,16'h0,   0));
        tbl.push_back(mk(0,1,0,0,0,0, 16'h0,16'h0,    1,0,0, 0,0, 0,0, 16'h0,16'h0,   0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0,0,1,0,0,0, 16'h20+16'(i), 16'hB0+16'(i),
                             1,0,0, 32'(i+1),0, 1, 3'(i+1), 16'h20,16'hB0, 0));
        tbl.push_back(mk(0,0,1,0,0,1, 16'h24,16'hB4,  1,0,0, 5,0, 1,4, 16'h21,16'hB1, 0));
        tbl.push_back(mk(0,0,0,1,1,1, 16'h0,16'h0,    1,0,0, 6,1, 1,3, 16'h22,16'hB2, 0));
        tbl.push_back(mk(0,0,0,0,0,1, 16'h0,16'h0,    1,0,0, 7,1, 1,2, 16'h23,16'hB3, 0));
        tbl.push_back(mk(0,0,0,0,0,1, 16'h0,16'h0,    1,0,0, 8,1, 1,1, 16'h24,16'hB4, 0));
        tbl.push_back(mk(0,0,0,0,0,1, 16'h0,16'h0,    1,0,0, 9,1, 0,0, 16'h0,16'h0,   0));
        tbl.push_back(mk(1,0,0,0,0,0, 16'h0,16'h0,    0,0,0, 0,0, 0,0, 16'h0,16'h0,   0));

        #23;
        check_outs("reset", 0,0,0, 0,0, 0,0, 16'h0,16'h0, 0);
        chk("reset.state", {30'd0, dbg_state}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Kill write after 5 idle RUN cycles.
        step(0,1,0,0,0,0, 16'h0,16'h0);
        check_outs("start1", 1,0,0, 0,0, 0,0, 16'h0,16'h0, 0);
        idle_steps(5);
        chk("idle5.cycles", cycle_cnt, 32'd5);
        step(0,0,1,0,0,0, 16'hFFFF,16'h1234);
        check_outs("kill", 0,1,0, 6,0, 0,0, 16'h0,16'h0, 0);
        chk("kill.state", {30'd0, dbg_state}, 32'd2);
        step(0,1,0,0,0,0, 16'h0,16'h0);
        check_outs("start_in_halt", 0,1,0, 6,0, 0,0, 16'h0,16'h0, 0);
        step(1,0,0,0,0,0, 16'h0,16'h0);
        check_outs("clear1", 0,0,0, 0,0, 0,0, 16'h0,16'h0, 0);

        // Kill write stalled by Waitreq for three cycles.
        step(0,1,0,0,0,0, 16'h0,16'h0);
        for (int k = 1; k <= 3; k++) begin
            step(0,0,1,0,1,0, 16'hFFFF,16'h0);
            check_outs($sformatf("stall%0d", k), 1,0,0, 32'(k),32'(k), 0,0, 16'h0,16'h0, 0);
        end
        step(0,0,1,0,0,0, 16'hFFFF,16'h0);
        check_outs("stall_kill", 0,1,0, 4,3, 0,0, 16'h0,16'h0, 0);
        step(1,0,0,0,0,0, 16'h0,16'h0);

        // Timeout after 20 RUN cycles; requests in TIMEOUT are ignored.
        step(0,1,0,0,0,0, 16'h0,16'h0);
        idle_steps(19);
        check_outs("pre_timeout", 1,0,0, 19,0, 0,0, 16'h0,16'h0, 0);
        idle_steps(1);
        check_outs("timeout", 0,0,1, 20,0, 0,0, 16'h0,16'h0, 0);
        step(0,0,1,1,1,0, 16'h40,16'h0);
        check_outs("timeout_hold", 0,0,1, 20,0, 0,0, 16'h0,16'h0, 0);
        step(1,0,0,0,0,0, 16'h0,16'h0);
        check_outs("clear2", 0,0,0, 0,0, 0,0, 16'h0,16'h0, 0);

        foreach (tbl[i]) begin
            step(tbl[i].clr, tbl[i].st, tbl[i].w, tbl[i].r, tbl[i].wq, tbl[i].p, tbl[i].a, tbl[i].d);
            check_outs($sformatf("vec%0d", i), tbl[i].e_en, tbl[i].e_halt, tbl[i].e_to,
                       tbl[i].e_cyc, tbl[i].e_stall, tbl[i].e_valid, tbl[i].e_cnt,
                       tbl[i].e_addr, tbl[i].e_data, tbl[i].e_ovf);
        end

        // Kill lands on the same cycle as the timeout: kill wins.
        step(0,1,0,0,0,0, 16'h0,16'h0);
        idle_steps(19);
        step(0,0,1,0,0,0, 16'hFFFF,16'h0);
        check_outs("kill_vs_timeout", 0,1,0, 20,0, 0,0, 16'h0,16'h0, 0);
        step(1,0,0,0,0,0, 16'h0,16'h0);
        check_outs("clear3", 0,0,0, 0,0, 0,0, 16'h0,16'h0, 0);
        step(0,1,0,0,0,0, 16'h0,16'h0);
        check_outs("rerun0", 1,0,0, 0,0, 0,0, 16'h0,16'h0, 0);
        idle_steps(1);
        check_outs("rerun1", 1,0,0, 1,0, 0,0, 16'h0,16'h0, 0);

        // Asynchronous reset in the middle of a run, away from any clock edge.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_outs("async_reset", 0,0,0, 0,0, 0,0, 16'h0,16'h0, 0);
        chk("async_reset.state", {30'd0, dbg_state}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_steps(1);
        chk("after_reset.enable", {31'd0, enable}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
